// File: rtl/mem_ctrl_if.sv
// Requester and RAM-side signal bundle for mem_ctrl.
// The controller connects through "slave"; the requesters/RAM side through "master".
interface mem_ctrl_if #(
    parameter int RAM_ADDR_W = 17
);
    logic                  if_req;
    logic [31:0]           if_addr;
    logic                  if_cancel;
    logic                  if_mem_ctrl_done;
    logic [31:0]           if_rdata;

    logic                  mem_req;
    logic                  mem_we;
    logic [1:0]            mem_size;
    logic [31:0]           mem_addr;
    logic [31:0]           mem_wdata;
    logic                  mem_mem_ctrl_done;
    logic [31:0]           mem_rdata;

    logic [RAM_ADDR_W-1:0] ram_addr;
    logic [7:0]            ram_dout;
    logic                  ram_wr;
    logic [7:0]            ram_din;

    modport master (
        output if_req, if_addr, if_cancel,
        output mem_req, mem_we, mem_size, mem_addr, mem_wdata,
        output ram_din,
        input  if_mem_ctrl_done, if_rdata,
        input  mem_mem_ctrl_done, mem_rdata,
        input  ram_addr, ram_dout, ram_wr
    );

    modport slave (
        input  if_req, if_addr, if_cancel,
        input  mem_req, mem_we, mem_size, mem_addr, mem_wdata,
        input  ram_din,
        output if_mem_ctrl_done, if_rdata,
        output mem_mem_ctrl_done, mem_rdata,
        output ram_addr, ram_dout, ram_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates fetch vs. load/store and
// splits each access into 1/2/4 little-endian transfers on a byte-wide RAM.
module mem_ctrl #(
    parameter int RAM_ADDR_W = 17
) (
    input  logic      clk,
    input  logic      rst,
    mem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] base;
    logic [2:0]  n;
    logic [2:0]  cnt;
    logic [2:0]  cnt_m1;
    logic        owner_mem;
    logic [31:0] asm_word;
    logic [31:0] asm_next;
    logic [31:0] if_rdata;
    logic [31:0] mem_rdata;
    logic        accept_mem;
    logic        accept_if;
    logic        last_rd;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                                input logic [1:0]  idx,
                                                input logic [7:0]  b);
        logic [31:0] w;
        w = word;
        w[{idx, 3'b000} +: 8] = b;
        return w;
    endfunction

    // RAM returns the byte addressed last cycle, so capture lags cnt by one
    assign cnt_m1   = cnt - 3'd1;
    assign asm_next = (cnt != 3'd0) ? insert_byte(asm_word, cnt_m1[1:0], bus.ram_din)
                                    : asm_word;

    always_comb begin
        state_next = state;
        accept_mem = 1'b0;
        accept_if  = 1'b0;
        last_rd    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.mem_req) begin
                    accept_mem = 1'b1;
                    state_next = bus.mem_we ? WR : RD;
                end else if (bus.if_req && !bus.if_cancel) begin
                    accept_if  = 1'b1;
                    state_next = RD;
                end
            end
            RD: begin
                if (!owner_mem && bus.if_cancel) begin
                    state_next = IDLE;
                end else if (cnt == n) begin
                    last_rd    = 1'b1;
                    state_next = DONE;
                end
            end
            WR: begin
                if (cnt == n - 3'd1) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            n         <= 3'd0;
            base      <= 32'd0;
            owner_mem <= 1'b0;
            asm_word  <= 32'd0;
            if_rdata  <= 32'd0;
            mem_rdata <= 32'd0;
        end else begin
            state <= state_next;
            if (accept_mem) begin
                base      <= bus.mem_addr;
                n         <= size_bytes(bus.mem_size);
                owner_mem <= 1'b1;
                cnt       <= 3'd0;
                asm_word  <= 32'd0;
            end else if (accept_if) begin
                base      <= bus.if_addr;
                n         <= 3'd4;
                owner_mem <= 1'b0;
                cnt       <= 3'd0;
                asm_word  <= 32'd0;
            end else if (state == RD) begin
                cnt      <= cnt + 3'd1;
                asm_word <= asm_next;
            end else if (state == WR) begin
                cnt <= cnt + 3'd1;
            end else if (state == DONE) begin
                cnt <= 3'd0;
            end
            if (last_rd) begin
                if (owner_mem) mem_rdata <= asm_next;
                else           if_rdata  <= asm_next;
            end
        end
    end

    // 32-bit add wraps before truncation to the RAM width
    assign bus.ram_addr = RAM_ADDR_W'(base + {29'd0, cnt});
    assign bus.ram_dout = (state == WR) ? bus.mem_wdata[{cnt[1:0], 3'b000} +: 8] : 8'h00;
    assign bus.ram_wr   = (state == WR) && !rst;

    assign bus.if_mem_ctrl_done  = (state == DONE) && !owner_mem && !bus.if_cancel;
    assign bus.mem_mem_ctrl_done = (state == DONE) && owner_mem;
    assign bus.if_rdata          = if_rdata;
    assign bus.mem_rdata         = mem_rdata;
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte RAM model and a done-pulse scoreboard.
module tb_mem_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_ctrl_if #(.RAM_ADDR_W(17)) bus ();
    mem_ctrl #(.RAM_ADDR_W(17)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [7:0]  ram [0:131071];
    logic        pl_en = 1'b0;
    logic [16:0] pl_addr = 17'd0;
    logic [7:0]  pl_data = 8'd0;

    always @(posedge clk) begin
        if (pl_en)            ram[pl_addr] <= pl_data;
        else if (bus.ram_wr)  ram[bus.ram_addr] <= bus.ram_dout;
        bus.ram_din <= ram[bus.ram_addr];
    end

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        chk;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t if_q[$];
    exp_t mem_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the next queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0) begin
            if (bus.if_mem_ctrl_done === 1'b1) begin
                if (if_q.size() == 0) check("if_unexpected_done", 32'd1, 32'd0);
                else begin
                    e = if_q.pop_front();
                    check("if_done_cycle", cyc, e.cyc);
                    if (e.chk) check("if_rdata", bus.if_rdata, e.data);
                end
            end
            if (bus.mem_mem_ctrl_done === 1'b1) begin
                if (mem_q.size() == 0) check("mem_unexpected_done", 32'd1, 32'd0);
                else begin
                    e = mem_q.pop_front();
                    check("mem_done_cycle", cyc, e.cyc);
                    if (e.chk) check("mem_rdata", bus.mem_rdata, e.data);
                end
            end
        end
    end

    task automatic poke(input logic [16:0] a, input logic [7:0] d);
        pl_addr = a; pl_data = d; pl_en = 1'b1;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input bit mem_side, input int budget, output bit wr_seen);
        bit got;
        got = 1'b0;
        wr_seen = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (bus.ram_wr === 1'b1) wr_seen = 1'b1;
            got = mem_side ? bus.mem_mem_ctrl_done : bus.if_mem_ctrl_done;
        end
        if (!got) check(mem_side ? "mem_done_timeout" : "if_done_timeout", 32'd0, 32'd1);
    endtask

    function automatic exp_t mk(input logic chk, input logic [31:0] data, input int c);
        exp_t e;
        e.chk = chk; e.data = data; e.cyc = c;
        return e;
    endfunction

    initial begin
        int t0;
        bit wr_seen;
        logic [16:0] wrap_addr [4];
        wrap_addr[0] = 17'h1FFFE; wrap_addr[1] = 17'h1FFFF;
        wrap_addr[2] = 17'h00000; wrap_addr[3] = 17'h00001;

        bus.if_req = 1'b0; bus.if_addr = 32'd0; bus.if_cancel = 1'b0;
        bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_size = 2'b00;
        bus.mem_addr = 32'd0; bus.mem_wdata = 32'd0;
        rst = 1'b1;

        // RAM image loaded while the controller is held in reset
        poke(17'h100, 8'h13); poke(17'h101, 8'h05); poke(17'h102, 8'h10); poke(17'h103, 8'h00);
        poke(17'h104, 8'h93); poke(17'h105, 8'h85); poke(17'h106, 8'hC5); poke(17'h107, 8'h04);
        poke(17'h200, 8'hEF); poke(17'h201, 8'hBE); poke(17'h202, 8'hAD); poke(17'h203, 8'hDE);
        poke(17'h300, 8'h11); poke(17'h301, 8'h22); poke(17'h302, 8'h33); poke(17'h303, 8'h77);
        poke(17'h400, 8'h5A); poke(17'h401, 8'h5A); poke(17'h402, 8'h5A); poke(17'h403, 8'h5A);
        poke(17'h1FFFE, 8'h44); poke(17'h1FFFF, 8'h33); poke(17'h00000, 8'h22); poke(17'h00001, 8'h11);

        @(negedge clk);
        check("rst_ram_wr",   {31'd0, bus.ram_wr}, 32'd0);
        check("rst_ram_addr", {15'd0, bus.ram_addr}, 32'd0);
        check("rst_ram_dout", {24'd0, bus.ram_dout}, 32'd0);
        check("rst_if_done",  {31'd0, bus.if_mem_ctrl_done}, 32'd0);
        check("rst_mem_done", {31'd0, bus.mem_mem_ctrl_done}, 32'd0);
        check("rst_if_rdata", bus.if_rdata, 32'd0);
        check("rst_mem_rdata", bus.mem_rdata, 32'd0);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // Fetch word
        bus.if_req = 1'b1; bus.if_addr = 32'h100; t0 = cyc;
        if_q.push_back(mk(1'b1, 32'h00100513, t0 + 6));
        wait_done(1'b0, 12, wr_seen);
        check("fetch_no_ram_wr", {31'd0, wr_seen}, 32'd0);
        next_cycle();
        bus.if_req = 1'b0;
        next_cycle();

        // Simultaneous requests: MEM first, fetch follows
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_size = 2'b10; bus.mem_addr = 32'h200;
        t0 = cyc;
        mem_q.push_back(mk(1'b1, 32'hDEADBEEF, t0 + 6));
        if_q.push_back(mk(1'b1, 32'h00100513, t0 + 13));
        wait_done(1'b1, 12, wr_seen);
        next_cycle();
        bus.mem_req = 1'b0;
        wait_done(1'b0, 12, wr_seen);
        next_cycle();
        bus.if_req = 1'b0;
        next_cycle();

        // Store half 0x1234ABCD at 0x301
        bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_size = 2'b01;
        bus.mem_addr = 32'h301; bus.mem_wdata = 32'h1234ABCD; t0 = cyc;
        mem_q.push_back(mk(1'b0, 32'd0, t0 + 3));
        wait_cyc(t0 + 1); @(negedge clk);
        check("sth_wr_c1",   {31'd0, bus.ram_wr}, 32'd1);
        check("sth_addr_c1", {15'd0, bus.ram_addr}, 32'h301);
        check("sth_dout_c1", {24'd0, bus.ram_dout}, 32'hCD);
        wait_cyc(t0 + 2); @(negedge clk);
        check("sth_wr_c2",   {31'd0, bus.ram_wr}, 32'd1);
        check("sth_addr_c2", {15'd0, bus.ram_addr}, 32'h302);
        check("sth_dout_c2", {24'd0, bus.ram_dout}, 32'hAB);
        wait_done(1'b1, 8, wr_seen);
        next_cycle();
        bus.mem_req = 1'b0; bus.mem_we = 1'b0;
        next_cycle();
        check("sth_ram_300", {24'd0, ram[17'h300]}, 32'h11);
        check("sth_ram_301", {24'd0, ram[17'h301]}, 32'hCD);
        check("sth_ram_302", {24'd0, ram[17'h302]}, 32'hAB);
        check("sth_ram_303", {24'd0, ram[17'h303]}, 32'h77);

        // Load byte 0x302, upper bytes must be zero
        bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_size = 2'b00; bus.mem_addr = 32'h302;
        t0 = cyc;
        mem_q.push_back(mk(1'b1, 32'h000000AB, t0 + 3));
        wait_done(1'b1, 8, wr_seen);
        next_cycle();
        bus.mem_req = 1'b0;
        next_cycle();

        // Cancel mid-fetch, then refetch at 0x104
        bus.if_req = 1'b1; bus.if_addr = 32'h100; t0 = cyc;
        wait_cyc(t0 + 3);
        bus.if_cancel = 1'b1;
        wait_cyc(t0 + 4);
        bus.if_cancel = 1'b0; bus.if_addr = 32'h104;
        if_q.push_back(mk(1'b1, 32'h04C58593, t0 + 10));
        wait_done(1'b0, 12, wr_seen);
        check("cancel_no_ram_wr", {31'd0, wr_seen}, 32'd0);
        next_cycle();
        bus.if_req = 1'b0;
        next_cycle();

        // Reset in cycle 2 of a word store
        bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_size = 2'b10;
        bus.mem_addr = 32'h400; bus.mem_wdata = 32'hA1B2C3D4; t0 = cyc;
        wait_cyc(t0 + 2);
        rst = 1'b1;
        @(negedge clk);
        check("rstw_wr_gated", {31'd0, bus.ram_wr}, 32'd0);
        wait_cyc(t0 + 3);
        rst = 1'b0; bus.mem_req = 1'b0; bus.mem_we = 1'b0;
        @(negedge clk);
        check("rstw_ram_wr",    {31'd0, bus.ram_wr}, 32'd0);
        check("rstw_ram_addr",  {15'd0, bus.ram_addr}, 32'd0);
        check("rstw_ram_dout",  {24'd0, bus.ram_dout}, 32'd0);
        check("rstw_if_rdata",  bus.if_rdata, 32'd0);
        check("rstw_mem_rdata", bus.mem_rdata, 32'd0);
        repeat (6) next_cycle();
        check("rstw_ram_400", {24'd0, ram[17'h400]}, 32'hD4);
        check("rstw_ram_401", {24'd0, ram[17'h401]}, 32'h5A);
        check("rstw_ram_403", {24'd0, ram[17'h403]}, 32'h5A);

        // Address wrap on a word load at 0xFFFFFFFE
        bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_size = 2'b10;
        bus.mem_addr = 32'hFFFFFFFE; t0 = cyc;
        mem_q.push_back(mk(1'b1, 32'h11223344, t0 + 6));
        for (int k = 0; k < 4; k++) begin
            wait_cyc(t0 + 1 + k); @(negedge clk);
            check("wrap_addr", {15'd0, bus.ram_addr}, {15'd0, wrap_addr[k]});
        end
        wait_done(1'b1, 8, wr_seen);
        next_cycle();
        bus.mem_req = 1'b0;
        repeat (4) next_cycle();

        check("if_queue_drained",  if_q.size(), 32'd0);
        check("mem_queue_drained", mem_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
